// File: rtl/vx_gpr_pkg.sv
// Shared constants, types and helpers for the per-warp GPR read stage.
package vx_gpr_pkg;

  // Default geometry of the register file.
  localparam int XLEN         = 32;
  localparam int RS_BITS      = 6;
  localparam int NUM_REGS     = 64;
  localparam int NUM_WARPS    = 4;
  localparam int NUM_THREADS  = 4;
  localparam int NW_BITS      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  // Three source operands per request: rs1, rs2, rs3 (ports 0, 1, 2).
  localparam int NUM_RD_PORTS = 3;

  // One word per lane, lane i at [i*XLEN +: XLEN].
  typedef logic [NUM_THREADS*XLEN-1:0] lane_vec_t;

  // x0 is hardwired to zero: never written, always read as 0.
  function automatic logic is_x0(input logic [RS_BITS-1:0] rs);
    return (rs == '0);
  endfunction

endpackage

// File: rtl/vx_gpr_ram.sv
// Register storage for one warp: one lane-masked write port and three read
// ports, built as three identical 1W1R copies that all take the same write.
// Reads are combinational; the enclosing stage owns the response registers,
// which gives the one-cycle read latency and read-before-write behaviour.
module vx_gpr_ram
  import vx_gpr_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int NUM_REGS    = 64,
  parameter int XLEN        = 32,
  localparam int AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int DW         = NUM_THREADS * XLEN
) (
  input  logic                               clk,
  input  logic                               wr_en_i,
  input  logic [NUM_THREADS-1:0]             wr_lane_en_i,
  input  logic [AW-1:0]                      wr_addr_i,
  input  logic [DW-1:0]                      wr_data_i,
  input  logic [NUM_RD_PORTS-1:0][AW-1:0]    rd_addr_i,
  output logic [NUM_RD_PORTS-1:0][DW-1:0]    rd_data_o
);

  for (genvar gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_copy
    logic [DW-1:0] mem_q [NUM_REGS];

    // Commit the active lanes of a writeback; inactive lanes keep their word.
    always_ff @(posedge clk) begin
      if (wr_en_i) begin
        for (int l = 0; l < NUM_THREADS; l++) begin
          if (wr_lane_en_i[l]) begin
            mem_q[wr_addr_i][l*XLEN +: XLEN] <= wr_data_i[l*XLEN +: XLEN];
          end
        end
      end
    end

    assign rd_data_o[gi] = mem_q[rd_addr_i[gi]];
  end

endmodule

// File: rtl/vx_gpr_read_stage.sv
// Issue-stage GPR file: per-warp storage, warp select, x0 forcing, and the
// registered operand responses with stall hold and asynchronous clear.
module vx_gpr_read_stage #(
  parameter int CORE_ID     = 0,
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int NUM_REGS    = 64,
  parameter int XLEN        = 32,
  localparam int NW_BITS    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int DW         = NUM_THREADS * XLEN
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wb_valid,
  input  logic [NW_BITS-1:0]               wb_wid,
  input  logic [NUM_THREADS-1:0]           wb_tmask,
  input  logic [vx_gpr_pkg::RS_BITS-1:0]   wb_rd,
  input  logic [DW-1:0]                    wb_data,
  output logic                             wb_ready,
  input  logic [NW_BITS-1:0]               req_wid,
  input  logic [vx_gpr_pkg::RS_BITS-1:0]   req_rs1,
  input  logic [vx_gpr_pkg::RS_BITS-1:0]   req_rs2,
  input  logic [vx_gpr_pkg::RS_BITS-1:0]   req_rs3,
  input  logic                             stall,
  output logic [DW-1:0]                    rsp_rs1_data,
  output logic [DW-1:0]                    rsp_rs2_data,
  output logic [DW-1:0]                    rsp_rs3_data
);
  import vx_gpr_pkg::*;

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // Reject geometries the 6-bit register index cannot address.
  if (NUM_REGS > (1 << RS_BITS) || NUM_REGS < 2) begin : g_bad_num_regs
    $error("vx_gpr_read_stage: NUM_REGS out of range for a %0d-bit index", RS_BITS);
  end
  if (CORE_ID < 0) begin : g_bad_core_id
    $error("vx_gpr_read_stage: CORE_ID %0d must be non-negative", CORE_ID);
  end

  // True when a register index names a register that exists.
  function automatic logic idx_ok(input logic [RS_BITS-1:0] idx);
    return (int'(idx) < NUM_REGS);
  endfunction

  // Writeback is never back-pressured.
  assign wb_ready = 1'b1;

  // ---------------------------------------------------------------------------
  // Writeback decode. Writes to x0 or to nonexistent registers are dropped,
  // and nothing commits while reset is held.
  // ---------------------------------------------------------------------------
  logic          wr_ok;
  logic [AW-1:0] wr_addr;

  assign wr_ok   = wb_valid && !reset && !is_x0(wb_rd) && idx_ok(wb_rd);
  assign wr_addr = wb_rd[AW-1:0];

  // ---------------------------------------------------------------------------
  // Read addressing, port order rs1, rs2, rs3.
  // ---------------------------------------------------------------------------
  logic [NUM_RD_PORTS-1:0][RS_BITS-1:0] rd_idx;
  logic [NUM_RD_PORTS-1:0][AW-1:0]      ram_addr;

  assign rd_idx = {req_rs3, req_rs2, req_rs1};

  for (genvar gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_addr
    assign ram_addr[gi] = rd_idx[gi][AW-1:0];
  end

  // ---------------------------------------------------------------------------
  // One storage block per warp; each sees only writebacks for its own id.
  // ---------------------------------------------------------------------------
  logic [NUM_RD_PORTS-1:0][DW-1:0] warp_rd [NUM_WARPS];

  for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
    logic warp_we;

    assign warp_we = wr_ok && (wb_wid == NW_BITS'(gi));

    vx_gpr_ram #(
      .NUM_THREADS (NUM_THREADS),
      .NUM_REGS    (NUM_REGS),
      .XLEN        (XLEN)
    ) u_ram (
      .clk          (clk),
      .wr_en_i      (warp_we),
      .wr_lane_en_i (wb_tmask),
      .wr_addr_i    (wr_addr),
      .wr_data_i    (wb_data),
      .rd_addr_i    (ram_addr),
      .rd_data_o    (warp_rd[gi])
    );
  end

  // ---------------------------------------------------------------------------
  // Response registers.
  // ---------------------------------------------------------------------------
  logic [NUM_RD_PORTS-1:0][DW-1:0] rsp_q;
  logic [NUM_RD_PORTS-1:0][DW-1:0] rsp_d;

  // Select the requested warp's operands, zero x0 / invalid indices, and hold on stall.
  always_comb begin
    rsp_d = rsp_q;
    if (!stall) begin
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        rsp_d[p] = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
          if (req_wid == NW_BITS'(w)) begin
            rsp_d[p] = warp_rd[w][p];
          end
        end
        if (is_x0(rd_idx[p]) || !idx_ok(rd_idx[p])) begin
          rsp_d[p] = '0;
        end
      end
    end
  end

  // Register the operands; reset clears them at once and drops any pending read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_q <= '0;
    end else begin
      rsp_q <= rsp_d;
    end
  end

  assign rsp_rs1_data = rsp_q[0];
  assign rsp_rs2_data = rsp_q[1];
  assign rsp_rs3_data = rsp_q[2];

endmodule

// File: tb/tb_vx_gpr_read_stage.sv
// Scoreboard bench for vx_gpr_read_stage: the driver predicts each cycle's
// response from an array model of the register file and queues it; a monitor
// compares the DUT outputs against the queue on every falling edge.
module tb_vx_gpr_read_stage;
  import vx_gpr_pkg::*;

  localparam int NW = 4;
  localparam int NT = 4;
  localparam int NR = 64;
  localparam int DW = NT * 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wb_valid = 1'b0;
  logic [1:0]        wb_wid = '0;
  logic [NT-1:0]     wb_tmask = '0;
  logic [5:0]        wb_rd = '0;
  logic [DW-1:0]     wb_data = '0;
  logic              wb_ready;
  logic [1:0]        req_wid = '0;
  logic [5:0]        req_rs1 = '0;
  logic [5:0]        req_rs2 = '0;
  logic [5:0]        req_rs3 = '0;
  logic              stall = 1'b0;
  logic [DW-1:0]     rsp_rs1_data;
  logic [DW-1:0]     rsp_rs2_data;
  logic [DW-1:0]     rsp_rs3_data;

  always #5 clk = ~clk;

  vx_gpr_read_stage #(
    .CORE_ID     (0),
    .NUM_WARPS   (NW),
    .NUM_THREADS (NT),
    .NUM_REGS    (NR),
    .XLEN        (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wb_valid     (wb_valid),
    .wb_wid       (wb_wid),
    .wb_tmask     (wb_tmask),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_ready     (wb_ready),
    .req_wid      (req_wid),
    .req_rs1      (req_rs1),
    .req_rs2      (req_rs2),
    .req_rs3      (req_rs3),
    .stall        (stall),
    .rsp_rs1_data (rsp_rs1_data),
    .rsp_rs2_data (rsp_rs2_data),
    .rsp_rs3_data (rsp_rs3_data)
  );

  // Reference register file: value and "has been written" flag per lane.
  int unsigned model_val [NW][NR][NT];
  bit          model_known [NW][NR][NT];

  typedef struct {
    logic [2:0][DW-1:0] data;
    logic [2:0][NT-1:0] known;
    int                 id;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   checks = 0;
  int   fails  = 0;
  int   txn    = 0;

  task automatic check_vec(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic exp_t zero_exp();
    exp_t e;
    e.data  = '0;
    e.known = '1;
    e.id    = 0;
    return e;
  endfunction

  // Advance one clock: predict the response registered at this edge, then
  // apply the writeback to the model (reads see the pre-write contents).
  task automatic step();
    exp_t e;
    logic [5:0] rs [3];
    @(posedge clk);
    rs[0] = req_rs1; rs[1] = req_rs2; rs[2] = req_rs3;
    if (reset) begin
      e = zero_exp();
    end else if (stall) begin
      e = last_exp;
    end else begin
      e = zero_exp();
      for (int p = 0; p < 3; p++) begin
        if (rs[p] != 0 && int'(rs[p]) < NR && int'(req_wid) < NW) begin
          for (int l = 0; l < NT; l++) begin
            e.data[p][l*32 +: 32] = model_val[req_wid][rs[p]][l];
            e.known[p][l]         = model_known[req_wid][rs[p]][l];
          end
        end
      end
    end
    e.id = txn;
    txn++;
    exp_q.push_back(e);
    last_exp = e;
    if (!reset && wb_valid && wb_rd != 0 && int'(wb_rd) < NR) begin
      for (int l = 0; l < NT; l++) begin
        if (wb_tmask[l]) begin
          model_val[wb_wid][wb_rd][l]   = wb_data[l*32 +: 32];
          model_known[wb_wid][wb_rd][l] = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic set_wb(input logic v, input int wid, input logic [NT-1:0] mask, input int rd,
                        input int unsigned d0, input int unsigned d1,
                        input int unsigned d2, input int unsigned d3);
    wb_valid = v;
    wb_wid   = 2'(wid);
    wb_tmask = mask;
    wb_rd    = 6'(rd);
    wb_data  = {d3, d2, d1, d0};
  endtask

  task automatic set_req(input int wid, input int r1, input int r2, input int r3, input logic st);
    req_wid = 2'(wid);
    req_rs1 = 6'(r1);
    req_rs2 = 6'(r2);
    req_rs3 = 6'(r3);
    stall   = st;
  endtask

  // Monitor: compare every registered response against the scoreboard.
  initial begin
    exp_t e;
    logic [2:0][DW-1:0] got;
    bit bad;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {rsp_rs3_data, rsp_rs2_data, rsp_rs1_data};
        for (int p = 0; p < 3; p++) begin
          if (e.known[p] != '0) begin
            bad = 1'b0;
            for (int l = 0; l < NT; l++) begin
              if (e.known[p][l] && got[p][l*32 +: 32] !== e.data[p][l*32 +: 32]) bad = 1'b1;
            end
            checks++;
            if (bad) begin
              fails++;
              $display("FAIL rsp_rs%0d txn %0d: got %h expected %h lanes %b",
                       p + 1, e.id, got[p], e.data[p], e.known[p]);
            end
          end
        end
        $display("txn %0d rs1=%h rs2=%h rs3=%h", e.id, got[0], got[1], got[2]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d queued responses", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    last_exp = zero_exp();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_vec("reset_rs1", rsp_rs1_data, '0);
    check_vec("reset_rs2", rsp_rs2_data, '0);
    check_vec("reset_rs3", rsp_rs3_data, '0);
    checks++;
    if (wb_ready !== 1'b1) begin
      fails++;
      $display("FAIL wb_ready: got %b expected 1", wb_ready);
    end
    @(negedge clk);
    #1 reset = 1'b0;

    // Fill every register of every warp so later reads are fully defined.
    for (int w = 0; w < NW; w++) begin
      for (int r = 1; r < NR; r++) begin
        set_wb(1'b1, w, 4'b1111, r, $urandom, $urandom, $urandom, $urandom);
        set_req($urandom_range(0, NW - 1), $urandom_range(0, NR - 1),
                $urandom_range(0, NR - 1), $urandom_range(0, NR - 1), 1'b0);
        step();
      end
    end

    // Full-mask write then read back.
    set_wb(1'b1, 1, 4'b1111, 5, 1, 2, 3, 4);
    set_req(0, 0, 0, 0, 1'b0);
    step();
    set_wb(1'b0, 0, 4'b0000, 0, 0, 0, 0, 0);
    set_req(1, 5, 0, 0, 1'b0);
    step();

    // Partial-mask overwrite, then warp isolation.
    set_wb(1'b1, 1, 4'b0101, 5, 32'hA, 32'hB, 32'hC, 32'hD);
    step();
    set_wb(1'b0, 0, 4'b0000, 0, 0, 0, 0, 0);
    set_req(1, 5, 5, 0, 1'b0);
    step();
    set_req(0, 5, 0, 5, 1'b0);
    step();

    // x0 writes are dropped; f0 is an ordinary register.
    set_wb(1'b1, 0, 4'b1111, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    step();
    set_wb(1'b1, 0, 4'b1111, 32, 7, 7, 7, 7);
    set_req(0, 0, 0, 0, 1'b0);
    step();
    set_wb(1'b0, 0, 4'b0000, 0, 0, 0, 0, 0);
    set_req(0, 32, 32, 32, 1'b0);
    step();

    // Same-cycle read and write of one register returns the old value.
    set_wb(1'b1, 2, 4'b1111, 9, 32'h11, 32'h11, 32'h11, 32'h11);
    step();
    set_wb(1'b1, 2, 4'b1111, 9, 32'h22, 32'h22, 32'h22, 32'h22);
    set_req(2, 0, 9, 0, 1'b0);
    step();
    set_wb(1'b0, 0, 4'b0000, 0, 0, 0, 0, 0);
    set_req(2, 9, 9, 9, 1'b0);
    step();

    // Stall holds the responses while requests change; writes still land.
    for (int i = 0; i < 3; i++) begin
      set_wb(1'b1, 3, 4'b1111, 20 + i, $urandom, $urandom, $urandom, $urandom);
      set_req($urandom_range(0, NW - 1), $urandom_range(1, NR - 1),
              $urandom_range(1, NR - 1), $urandom_range(1, NR - 1), 1'b1);
      step();
    end
    set_wb(1'b0, 0, 4'b0000, 0, 0, 0, 0, 0);
    set_req(3, 20, 21, 22, 1'b0);
    step();
    step();

    // Asynchronous reset between edges; a writeback during reset must not land.
    set_req(1, 5, 5, 5, 1'b0);
    step();
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check_vec("async_reset_rs1", rsp_rs1_data, '0);
    check_vec("async_reset_rs2", rsp_rs2_data, '0);
    check_vec("async_reset_rs3", rsp_rs3_data, '0);
    set_wb(1'b1, 2, 4'b1111, 7, 32'hDEAD, 32'hDEAD, 32'hDEAD, 32'hDEAD);
    step();
    @(negedge clk);
    #1 reset = 1'b0;
    set_wb(1'b0, 0, 4'b0000, 0, 0, 0, 0, 0);
    set_req(2, 7, 7, 7, 1'b0);
    step();
    step();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      int r1;
      set_wb(1'($urandom_range(0, 1)), $urandom_range(0, NW - 1), 4'($urandom),
             $urandom_range(0, NR - 1), $urandom, $urandom, $urandom, $urandom);
      r1 = $urandom_range(0, NR - 1);
      if ($urandom_range(0, 7) == 0) begin
        set_req($urandom_range(0, NW - 1), r1, r1, r1, 1'($urandom_range(0, 7) == 0));
      end else begin
        set_req($urandom_range(0, NW - 1), r1, $urandom_range(0, NR - 1),
                $urandom_range(0, NR - 1), 1'($urandom_range(0, 7) == 0));
      end
      step();
    end

    // Drain the scoreboard.
    set_wb(1'b0, 0, 4'b0000, 0, 0, 0, 0, 0);
    set_req(0, 0, 0, 0, 1'b0);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d queued responses expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
